// File: rtl/mole_dispatcher.sv
// Whack-a-mole dispatcher: picks a pseudo-random mole after a short gap, runs its
// active window, and reports synchronised hits on the selected switch.
module mole_dispatcher #(
  parameter int unsigned WIN_EASY   = 50_000_000,
  parameter int unsigned WIN_MED    = 25_000_000,
  parameter int unsigned WIN_HARD   = 12_500_000,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_for_mole,
  input  logic       timeout_start,
  input  logic       ledx,
  input  logic [1:0] level_select,
  input  logic [7:0] switches,
  output logic       rng_ready,
  output logic       timeout,
  output logic       switchx,
  output logic [2:0] mole_index,
  output logic [7:0] leds
);

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned SW_W    = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    ISSUE,
    ARMED,
    EXPIRED
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]   mole_q, mole_d;
  logic               seen_q, seen_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [SW_W-1:0]    sync1_q, sync1_d;
  logic [SW_W-1:0]    sync2_q, sync2_d;
  logic [SW_W-1:0]    sync3_q, sync3_d;
  logic               rng_q, rng_d;
  logic               tmo_q, tmo_d;
  logic               hit_q, hit_d;

  logic [SW_W-1:0]    rise;
  logic [IDX_W-1:0]   pick_raw;
  logic [IDX_W-1:0]   pick_idx;

  function automatic logic [TIMER_W-1:0] window_len(input logic [1:0] lvl);
    case (lvl)
      2'b00:   return TIMER_W'(WIN_EASY);
      2'b01:   return TIMER_W'(WIN_MED);
      default: return TIMER_W'(WIN_HARD);
    endcase
  endfunction

  // Galois LFSR free-runs so the mole choice depends on request timing.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
  end

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_comb begin
    sync1_d = switches;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise    = sync2_q & ~sync3_q;
  end

  // Never present the same mole twice in a row.
  always_comb begin
    pick_raw = lfsr_q[IDX_W-1:0];
    pick_idx = (pick_raw == mole_q) ? pick_raw + IDX_W'(1) : pick_raw;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    timer_d = timer_q;
    mole_d  = mole_q;
    seen_d  = seen_q;

    case (state_q)
      IDLE: begin
        if (ready_for_mole) begin
          state_d = GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (!ready_for_mole) begin
          state_d = IDLE;
        end else if (gap_q == '0) begin
          state_d = ISSUE;
          mole_d  = pick_idx;
          timer_d = window_len(level_select);
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ISSUE: begin
        state_d = ARMED;
        seen_d  = 1'b0;
      end
      ARMED: begin
        seen_d = seen_q | timeout_start;
        // A release after the game FSM picked up the window wins over expiry.
        if (seen_q && !timeout_start) begin
          state_d = IDLE;
          timer_d = '0;
          seen_d  = 1'b0;
        end else if (timer_q <= TIMER_W'(1)) begin
          state_d = EXPIRED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      EXPIRED: begin
        if (!timeout_start) begin
          state_d = IDLE;
          seen_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs registered from next-state so they line up with the state they describe.
  always_comb begin
    rng_d = (state_d == ISSUE);
    tmo_d = (state_d == ISSUE) || ((state_d == ARMED) && (timer_d != '0));
    hit_d = (state_q == ARMED) && tmo_q && rise[mole_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      timer_q <= '0;
      mole_q  <= '0;
      seen_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      rng_q   <= 1'b0;
      tmo_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      timer_q <= timer_d;
      mole_q  <= mole_d;
      seen_q  <= seen_d;
      lfsr_q  <= lfsr_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      rng_q   <= rng_d;
      tmo_q   <= tmo_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    leds = '0;
    if ((state_q == ARMED) && ledx) begin
      leds = SW_W'(1) << mole_q;
    end
  end

  assign rng_ready  = rng_q;
  assign timeout    = tmo_q;
  assign switchx    = hit_q;
  assign mole_index = mole_q;

  rng_single_cycle: assert property (@(posedge clk) disable iff (reset)
    rng_ready |=> !rng_ready);

  mole_hold: assert property (@(posedge clk) disable iff (reset)
    !((state_q == GAP) && (state_d == ISSUE)) |=> $stable(mole_index));

endmodule
